digit_serial_addsub: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through one DIGIT-bit ripple slice and a registered carry.
- Trades latency for area on wide datapaths.
- Start/busy/done handshake; results are registered and held until the next operation completes.

---
 rtl/digit_serial_addsub_if.sv | 28 ++
 rtl/digit_serial_addsub.sv | 130 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The requester drives start and operands; the unit returns the result, its status and the FSM state.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    // start is accepted on any edge where busy=0; done marks one cycle, and sum/cout/ovf are held until the next completion.
    modport master (
        output start, sub, a, b, cin,
        input  sum, cout, ovf, busy, done, state
    );

    modport slave (
        input  start, sub, a, b, cin,
        output sum, cout, ovf, busy, done, state
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-bit ripple slice per clock with a registered carry.
// The operands rotate right one digit per cycle and the partial result shifts in from the top.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    digit_serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             op_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] partial_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy;
    logic             done;

    logic             accept;
    logic             last_digit;
    logic [DIGIT:0]   slice_full;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_carry;
    logic [WIDTH+DIGIT-1:0] partial_ext;
    logic [WIDTH-1:0] partial_next;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [WIDTH-1:0] a_rot;
    logic [WIDTH-1:0] b_rot;

    assign accept     = (state_q != S_RUN) && bus.start;
    assign last_digit = (k_q == K_LAST);

    // The active digit always sits in the low DIGIT bits of the rotating operand copies.
    assign slice_full  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign slice_sum   = slice_full[DIGIT-1:0];
    assign slice_carry = slice_full[DIGIT];

    assign partial_ext  = {slice_sum, partial_q};
    assign partial_next = partial_ext[WIDTH+DIGIT-1:DIGIT];

    assign a_ext = {a_q, a_q};
    assign b_ext = {b_q, b_q};
    assign a_rot = a_ext[WIDTH+DIGIT-1:DIGIT];
    assign b_rot = b_ext[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = bus.start ? S_RUN : S_IDLE;
            S_RUN:          state_d = last_digit ? S_DONE : S_RUN;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            op_q      <= 1'b0;
            k_q       <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow_in; the borrow-out is the inverted final carry.
            a_q       <= bus.a;
            b_q       <= bus.sub ? ~bus.b : bus.b;
            carry_q   <= bus.sub ^ bus.cin;
            op_q      <= bus.sub;
            k_q       <= '0;
            partial_q <= '0;
        end else if (state_q == S_RUN) begin
            a_q       <= a_rot;
            b_q       <= b_rot;
            carry_q   <= slice_carry;
            partial_q <= partial_next;
            k_q       <= k_q + KW'(1);
            if (last_digit) begin
                sum_q  <= partial_next;
                cout_q <= op_q ^ slice_carry;
                ovf_q  <= (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice_sum[DIGIT-1] != a_q[DIGIT-1]);
            end
        end
    end

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.state = state_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub at WIDTH=16/DIGIT=4, plus reference-model
// sweeps of the WIDTH=16/DIGIT=16 and WIDTH=8/DIGIT=1 configurations.
module tb_digit_serial_addsub;
    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    digit_serial_addsub_if #(.WIDTH(16)) bus0 ();
    digit_serial_addsub_if #(.WIDTH(16)) bus1 ();
    digit_serial_addsub_if #(.WIDTH(8))  bus2 ();

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add or subtract.
    function automatic logic [33:0] model(input int w, input logic s, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [63:0] mask, be, full, r;
        logic        cy, am, bm, rm;
        mask = (64'd1 << w) - 64'd1;
        be   = s ? (~{32'd0, b}) & mask : {32'd0, b};
        full = {32'd0, a} + be + {63'd0, (s ? ~c : c)};
        r    = full & mask;
        cy   = full[w];
        am   = a[w-1];
        bm   = be[w-1];
        rm   = r[w-1];
        return {(am == bm) && (rm != am), s ? ~cy : cy, r[31:0]};
    endfunction

    task automatic start0(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c);
        bus0.start = 1'b1;
        bus0.sub   = s;
        bus0.a     = a;
        bus0.b     = b;
        bus0.cin   = c;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus0.sub   = ~s;
        bus0.a     = 16'hDEAD;
        bus0.b     = 16'hBEEF;
        bus0.cin   = ~c;
    endtask

    task automatic wait_done0(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (bus0.done !== 1'b1 && edges < 40) begin
            if (bus0.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic op0(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] exp_sum, input logic exp_cout,
                       input logic exp_ovf);
        int edges, busy_cycles;
        start0(s, a, b, c);
        wait_done0(edges, busy_cycles);
        check({tag, "_lat"}, edges, 4);
        check({tag, "_busy"}, busy_cycles, 4);
        check({tag, "_sum"}, bus0.sum, exp_sum);
        check({tag, "_cout"}, bus0.cout, exp_cout);
        check({tag, "_ovf"}, bus0.ovf, exp_ovf);
        @(posedge clk); #1;
        check({tag, "_pulse"}, bus0.done, 1'b0);
    endtask

    task automatic rand_d16();
        for (int i = 0; i < 1000; i++) begin
            logic s, c;
            logic [15:0] a, b;
            logic [33:0] m;
            int edges;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            bus1.start = 1'b1; bus1.sub = s; bus1.a = a; bus1.b = b; bus1.cin = c;
            @(posedge clk); #1;
            bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b;
            edges = 0;
            while (bus1.done !== 1'b1 && edges < 40) begin
                @(posedge clk); #1;
                edges++;
            end
            m = model(16, s, {16'd0, a}, {16'd0, b}, c);
            check("d16_lat", edges, 1);
            check("d16_sum", {16'd0, bus1.sum}, m[31:0]);
            check("d16_cout", bus1.cout, m[32]);
            check("d16_ovf", bus1.ovf, m[33]);
        end
    endtask

    task automatic rand_d1();
        for (int i = 0; i < 1000; i++) begin
            logic s, c;
            logic [7:0] a, b;
            logic [33:0] m;
            int edges;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bus2.start = 1'b1; bus2.sub = s; bus2.a = a; bus2.b = b; bus2.cin = c;
            @(posedge clk); #1;
            bus2.start = 1'b0; bus2.a = ~a; bus2.b = ~b;
            edges = 0;
            while (bus2.done !== 1'b1 && edges < 40) begin
                @(posedge clk); #1;
                edges++;
            end
            m = model(8, s, {24'd0, a}, {24'd0, b}, c);
            check("d1_lat", edges, 8);
            check("d1_sum", {24'd0, bus2.sum}, m[31:0]);
            check("d1_cout", bus2.cout, m[32]);
            check("d1_ovf", bus2.ovf, m[33]);
        end
    endtask

    initial begin
        int edges, busy_cycles, dones;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", bus0.sum, 16'h0000);
        check("rst_cout", bus0.cout, 1'b0);
        check("rst_ovf", bus0.ovf, 1'b0);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_done", bus0.done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        op0("add_basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op0("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op0("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op0("add_cin",   1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        op0("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        op0("sub_ovf",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        op0("sub_bin",   1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 1'b0);

        // start while busy must be ignored
        start0(1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        bus0.start = 1'b1; bus0.a = 16'hAAAA; bus0.b = 16'h1111;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        wait_done0(edges, busy_cycles);
        check("midrun_lat", edges, 2);
        check("midrun_sum", bus0.sum, 16'h5555);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus0.done === 1'b1) dones++;
        end
        check("midrun_dones", dones, 0);
        check("midrun_idle", bus0.busy, 1'b0);

        // back-to-back start in the DONE cycle
        start0(1'b0, 16'h1234, 16'h4321, 1'b0);
        wait_done0(edges, busy_cycles);
        check("b2b_first", bus0.sum, 16'h5555);
        start0(1'b0, 16'h0001, 16'h0002, 1'b0);
        check("b2b_busy", bus0.busy, 1'b1);
        check("b2b_hold0", bus0.sum, 16'h5555);
        @(posedge clk); #1;
        check("b2b_hold1", bus0.sum, 16'h5555);
        wait_done0(edges, busy_cycles);
        check("b2b_lat", edges, 3);
        check("b2b_sum", bus0.sum, 16'h0003);
        @(posedge clk); #1;

        // reset on the second RUN edge abandons the operation
        start0(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", bus0.busy, 1'b0);
        check("abort_done", bus0.done, 1'b0);
        check("abort_sum", bus0.sum, 16'h0000);
        check("abort_cout", bus0.cout, 1'b0);
        check("abort_ovf", bus0.ovf, 1'b0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus0.done === 1'b1) dones++;
        end
        check("abort_dones", dones, 0);
        op0("after_rst", 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        rand_d16();
        rand_d1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
